// File: rtl/row_page_scheduler.sv
// Row-to-source page scheduler for the OLED text rows, with UART page control.
// Define ROW_MAP_WRITE_EN to enable the 'M' command that rewrites the page table.
module row_page_scheduler #(
   parameter logic [31:0] PAGE_TIME = 32'd27000000,
   parameter int          NUM_PAGES = 4
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic [5:0] charAddress,
   input  logic [9:0] pixelAddress,
   input  logic [7:0] srcChar0,
   input  logic [7:0] srcChar1,
   input  logic [7:0] srcChar2,
   input  logic [7:0] srcChar3,
   input  logic [7:0] textPixel,
   input  logic [7:0] graphicPixel,
   input  logic       rxReady,
   input  logic [7:0] rxData,
   output logic [7:0] charOutput,
   output logic [7:0] pixelOut,
   output logic [1:0] currentPage,
   output logic       frozen,
   output logic       cmdError
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_GOT_P  = 3'd1;
`ifdef ROW_MAP_WRITE_EN
   localparam logic [2:0] ST_M_PAGE = 3'd2;
   localparam logic [2:0] ST_M_ROW  = 3'd3;
   localparam logic [2:0] ST_M_SRC  = 3'd4;
`endif

   localparam logic [7:0] BLANK = 8'h20;

   // Packed as {page3..page0}, each page {row3..row0}
   localparam logic [3:0][3:0][2:0] MAP_DEFAULT = {
      {3'd0, 3'd1, 3'd2, 3'd3},
      {3'd1, 3'd1, 3'd0, 3'd0},
      {3'd5, 3'd4, 3'd3, 3'd2},
      {3'd4, 3'd2, 3'd1, 3'd0}
   };

   logic [31:0] timer_q, timer_d;
   logic [1:0]  page_q, page_d;
   logic        frozen_q, frozen_d;
   logic        cmd_error_q, cmd_error_d;
   logic [2:0]  state_q, state_d;
   logic [7:0]  char_output_q, char_output_d;
   logic [3:0][3:0][2:0] map;

`ifdef ROW_MAP_WRITE_EN
   logic [3:0][3:0][2:0] map_q, map_d;
   logic [1:0]  wr_page_q, wr_page_d;
   logic [1:0]  wr_row_q, wr_row_d;
   assign map = map_q;
`else
   assign map = MAP_DEFAULT;
`endif

   logic [7:0] rx_digit;
   logic [2:0] char_src;
   logic [2:0] pixel_src;
   logic [1:0] next_page;
   logic       unused_addr_bits;

   assign rx_digit  = rxData - 8'h30;
   assign char_src  = map[page_q][charAddress[5:4]];
   assign pixel_src = map[page_q][pixelAddress[9:8]];
   assign next_page = (page_q == 2'(NUM_PAGES - 1)) ? 2'd0 : page_q + 2'd1;
   assign unused_addr_bits = ^{charAddress[3:0], pixelAddress[7:0]};

   always_comb begin
      char_output_d = BLANK;
      unique case (char_src)
         3'd0:    char_output_d = srcChar0;
         3'd1:    char_output_d = srcChar1;
         3'd2:    char_output_d = srcChar2;
         3'd3:    char_output_d = srcChar3;
         default: char_output_d = BLANK;
      endcase
   end

   always_comb begin
      pixelOut = (pixel_src == 3'd4) ? graphicPixel : textPixel;
   end

   always_comb begin
      timer_d     = timer_q;
      page_d      = page_q;
      frozen_d    = frozen_q;
      state_d     = state_q;
      cmd_error_d = 1'b0;
`ifdef ROW_MAP_WRITE_EN
      map_d       = map_q;
      wr_page_d   = wr_page_q;
      wr_row_d    = wr_row_q;
`endif

      if (!frozen_q) begin
         if (timer_q == PAGE_TIME - 32'd1) begin
            timer_d = 32'd0;
            page_d  = next_page;
         end else begin
            timer_d = timer_q + 32'd1;
         end
      end

      // A page jump is evaluated after the timer so it overrides a wrap
      if (rxReady) begin
         unique case (state_q)
            ST_IDLE: begin
               if (rxData == "P") begin
                  state_d = ST_GOT_P;
               end else if (rxData == "F") begin
                  frozen_d = ~frozen_q;
               end else if (rxData == "M") begin
`ifdef ROW_MAP_WRITE_EN
                  state_d = ST_M_PAGE;
`else
                  cmd_error_d = 1'b1;
`endif
               end
            end
            ST_GOT_P: begin
               state_d = ST_IDLE;
               if (rx_digit < 8'(NUM_PAGES)) begin
                  page_d  = rx_digit[1:0];
                  timer_d = 32'd0;
               end else begin
                  cmd_error_d = 1'b1;
               end
            end
`ifdef ROW_MAP_WRITE_EN
            ST_M_PAGE: begin
               if (rx_digit < 8'd4) begin
                  wr_page_d = rx_digit[1:0];
                  state_d   = ST_M_ROW;
               end else begin
                  cmd_error_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
            ST_M_ROW: begin
               if (rx_digit < 8'd4) begin
                  wr_row_d = rx_digit[1:0];
                  state_d  = ST_M_SRC;
               end else begin
                  cmd_error_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end
            ST_M_SRC: begin
               state_d = ST_IDLE;
               if (rx_digit < 8'd8) begin
                  map_d[wr_page_q][wr_row_q] = rx_digit[2:0];
               end else begin
                  cmd_error_d = 1'b1;
               end
            end
`endif
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         timer_q       <= 32'd0;
         page_q        <= 2'd0;
         frozen_q      <= 1'b0;
         cmd_error_q   <= 1'b0;
         state_q       <= ST_IDLE;
         char_output_q <= BLANK;
`ifdef ROW_MAP_WRITE_EN
         map_q         <= MAP_DEFAULT;
         wr_page_q     <= 2'd0;
         wr_row_q      <= 2'd0;
`endif
      end else begin
         timer_q       <= timer_d;
         page_q        <= page_d;
         frozen_q      <= frozen_d;
         cmd_error_q   <= cmd_error_d;
         state_q       <= state_d;
         char_output_q <= char_output_d;
`ifdef ROW_MAP_WRITE_EN
         map_q         <= map_d;
         wr_page_q     <= wr_page_d;
         wr_row_q      <= wr_row_d;
`endif
      end
   end

   assign charOutput  = char_output_q;
   assign currentPage = page_q;
   assign frozen      = frozen_q;
   assign cmdError    = cmd_error_q;

endmodule

// File: doc/row_page_scheduler.md
Name: row_page_scheduler

Overview:
- Shares the four text rows of the OLED display between up to five content sources: four character-row generators and one graphic-row generator.
- Holds a page table that maps each display row to a source index.
- Rotates pages on a timer and accepts page-jump, freeze and map-write commands from the UART byte stream.
- Sits between the text engine/screen driver and the row generators, and replaces the fixed per-row select in the top level.

Parameters:
- PAGE_TIME, 27000000: clocks per page before auto-advance (1 s at 27 MHz); legal range 2..2^32-1.
- NUM_PAGES, 4: pages in rotation; legal range 1..4.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous active-low reset
- charAddress  in  6  from text engine; [5:4] = row, [3:0] = column
- pixelAddress  in  10  from screen driver; [9:8] = display row
- srcChar0..srcChar3  in  8 each  character from row sources 0..3
- textPixel  in  8  text-engine pixel byte
- graphicPixel  in  8  graphic-row pixel byte (source 4)
- rxReady  in  1  one-cycle pulse, UART byte valid
- rxData  in  8  UART byte
- charOutput  out  8  registered character to text engine
- pixelOut  out  8  pixel byte to screen driver
- currentPage  out  2  page being displayed
- frozen  out  1  auto-rotation halted
- cmdError  out  1  one-cycle pulse on a malformed command

Behaviour:
- Reset (resetN=0 at a clk edge):
  - charOutput=0x20, currentPage=0, frozen=0, cmdError=0.
  - Timer=0, command FSM=IDLE.
  - Page table loaded with defaults (row0..row3 sources): page0 {0,1,2,4}, page1 {2,3,4,5}, page2 {0,0,1,1}, page3 {3,2,1,0}.
  - Reset mid-command abandons the partial command.
- Source index is 3 bits per entry:
  - 0..3 select srcChar0..3.
  - 4 selects graphic.
  - 5..7 mean blank.
- charOutput, registered with 1-cycle latency from charAddress. Take entry s = map[currentPage][charAddress[5:4]]:
  - s in 0..3: srcChar[s].
  - s = 4: 0x20 (graphic rows carry no text).
  - s in 5..7: 0x20.
- pixelOut, combinational. Take entry s = map[currentPage][pixelAddress[9:8]]:
  - s = 4: graphicPixel.
  - otherwise: textPixel.
- Timer:
  - When frozen=0, increments each clock.
  - At PAGE_TIME-1 it wraps to 0 and currentPage advances: (currentPage+1) mod NUM_PAGES.
  - When frozen=1, the timer holds its value.
  - With NUM_PAGES=1, the page stays 0.
- Command FSM, which advances only on rxReady:
  - IDLE:
    - 'P' goes to GOT_P.
    - 'F' toggles frozen and stays in IDLE.
    - 'M' goes to M_PAGE.
    - Any other byte is ignored silently.
  - GOT_P:
    - Digit d with '0'<=d<'0'+NUM_PAGES sets currentPage=d, timer=0, then IDLE.
    - Otherwise pulses cmdError, then IDLE.
  - M_PAGE: digit '0'..'3' is latched as the page, then M_ROW; otherwise error, then IDLE.
  - M_ROW: digit '0'..'3' is latched as the row, then M_SRC; otherwise error, then IDLE.
  - M_SRC: digit '0'..'7' writes map[page][row], then IDLE; otherwise error, then IDLE.
- A map write is visible to charOutput/pixelOut from the clock after the write edge.
- Map writes to pages >= NUM_PAGES are accepted and stored, but those pages are never displayed.
- Page jump coinciding with timer wrap: the jump wins; currentPage=d and timer=0.
- 'F' is accepted while frozen (it unfreezes).
- 'P' jumps are accepted while frozen; frozen stays set.

Optional Feature:
- Macro: ROW_MAP_WRITE_EN.
- Defined: the 'M' command and map writes operate as above.
- Undefined:
  - The page table is constant at the default values.
  - States M_PAGE/M_ROW/M_SRC do not exist.
  - 'M' in IDLE pulses cmdError and stays in IDLE.

Test Plan:
- Release reset with PAGE_TIME=20 and no UART traffic:
  - currentPage goes 0 -> 1 after 20 clocks, then 2, 3, and back to 0 at 80 clocks.
  - With page0 displayed, charAddress=0x12 gives charOutput=srcChar1 one clock later.
  - pixelAddress=0x300 gives pixelOut=graphicPixel.
- Send 'F', wait 100 clocks, then send 'F' again:
  - frozen=1 and currentPage is constant during the wait.
  - Rotation resumes from the held timer value.
- Send 'P','2' timed to arrive on the wrap cycle from page 0:
  - currentPage=2 and timer=0; the next advance is 20 clocks later.
- Send 'M','0','3','1' (ROW_MAP_WRITE_EN defined), then drive pixelAddress=0x300 and charAddress=0x35:
  - pixelOut=textPixel.
  - charOutput=srcChar1 one clock later.
- Error cases:
  - 'P','7' with NUM_PAGES=4 gives one cmdError pulse and no page change.
  - 'M','0','9' gives cmdError, FSM back in IDLE, and the next 'F' is honoured.
  - With ROW_MAP_WRITE_EN undefined, 'M' alone gives cmdError.
- Assert resetN low after 'M','1' has been received:
  - Map returns to defaults and FSM=IDLE.
  - A following '2' byte is ignored.
